fofb_read_link_gen: RTL and testbench
=====================================

Name: fofb_read_link_gen

Overview:
- Parametrised successor to the cell-link FOFB reader; sits on the auroraClk side of the cell-controller receive path.
- Parses AXI-stream BPM records into a per-BPM DPRAM, maintains BPM-present bitmap and per-frame cell count, and publishes per-packet status plus saturating error counters.
- Generalised payload length (PAYLOAD_WORDS) and configurable header magic.
- Single clock domain; readout port is synchronous to the same clock.

Parameters:
FOFB_INDEX_WIDTH, 9, BPM index width; DPRAM depth and bitmap width 2**FOFB_INDEX_WIDTH.
CELL_INDEX_WIDTH, 5, cell index field width.
PAYLOAD_WORDS, 3, 32-bit payload words per record; legal range 2..8.
HEADER_MAGIC, 16'hA5BE, required header bits 31:16.
COUNTER_WIDTH, 16, width of each status counter.

Ports:
auroraClk  in  1  clock
auroraReset  in  1  synchronous active-high reset
FAstrobe  in  1  fast-acquisition frame start
allBPMpresent  in  1  inhibits DPRAM writes and bitmap merges when high
TVALID  in  1  stream beat valid (no backpressure)
TLAST  in  1  last beat of packet
TDATA  in  32  stream data
statusStrobe  out  1  one-cycle pulse: status fields valid
statusCode  out  2  0 success, 1 bad header, 2 bad size, 3 bad packet
statusFOFBenabled  out  1  header bit 15 of latest record
statusCellIndex  out  CELL_INDEX_WIDTH  header bits 10+: of latest record
bpmBitmap  out  2**FOFB_INDEX_WIDTH  BPMs received this frame
cellCounter  out  CELL_INDEX_WIDTH+1  good packets this frame
countSuccess, countBadHeader, countBadSize, countBadPacket  out  COUNTER_WIDTH each  saturating event counters
counterClear  in  1  zeroes the four counters
readoutAddress  in  FOFB_INDEX_WIDTH  DPRAM read address
readoutData  out  32*PAYLOAD_WORDS  record; word k at bits 32k+:32

Behaviour:
- Reset: state HEADER, all outputs, counters, bitmap, packet map and internal toggles 0. DPRAM contents not cleared by reset (zero at configuration).
- Packet = one or more records; record = header beat + PAYLOAD_WORDS payload beats. Header: magic 31:16, FOFBenabled 15, cellIndex 10+:, fofbIndex 0+:. Final payload word: bit31 = BPM absent (no write), bit30 = bad packet.
- States: HEADER, PAYLOAD (word index w = 0..PAYLOAD_WORDS-1), DISCARD. Advance only on TVALID.
- Priority per cycle: auroraReset > FAstrobe > TVALID beat.
- FAstrobe: clear bpmBitmap, cellCounter, packet map; state HEADER; concurrent beat ignored; no status pulse; in-flight write suppressed.
- TLAST on any beat other than final payload word, while not in DISCARD: status bad size; state HEADER.
- HEADER, magic match: latch index, cell, enable; w=0; go PAYLOAD. Mismatch: status bad header; go DISCARD.
- PAYLOAD: store word w; w+1 until final word. Final word: if !bit31, set packet map[fofbIndex]; if also !allBPMpresent, DPRAM write of full record at fofbIndex in the following cycle. With TLAST: bit30 -> bad packet; else success, cellCounter+1, and (if !allBPMpresent) merge packet map into bpmBitmap next cycle. Return to HEADER either way.
- DISCARD: ignore beats; TLAST returns to HEADER silently.
- Packet map clears at first header after any packet end, bad status or FAstrobe.
- Status latency: statusStrobe and statusCode valid exactly one cycle after the terminating beat; strobe high one cycle.
- Counters: increment with statusStrobe per code; saturate at all-ones. counterClear zeroes them; clear beats same-cycle increment.
- cellCounter wraps modulo 2**(CELL_INDEX_WIDTH+1).
- Readout: readoutData registered, one-cycle latency. Read and write to same address in one cycle returns old data.

Test Plan:
- Good packet: header 0xA5BE_8405 (enable 1, cell 1, index 5), payloads 1,2,0x0000_0003 with TLAST -> statusCode 0, cellCounter 1, bpmBitmap bit5, readoutAddress 5 -> {3,2,1}, countSuccess 1.
- Bad magic 0x1234_0005 then 3 beats, TLAST on last -> one pulse code 1; no DPRAM write; countBadHeader 1.
- TLAST on second payload beat -> code 2 one cycle later; next header parsed normally.
- Final word 0x4000_0000 with TLAST -> code 3; DPRAM written; bitmap unchanged; cellCounter unchanged.
- Final word 0x8000_0000, or allBPMpresent=1 -> no DPRAM write; with allBPMpresent=1 bitmap stays 0 while cellCounter still increments.
- FAstrobe mid-record, then a full good packet -> no status for the aborted record; bitmap holds only the new index. Force countBadSize to all-ones, send a bad-size packet -> count holds at all-ones.

Source files
------------

// File: rtl/fofb_read_link_gen_if.sv
// ---------------------------------------------------------------------------
// fofb_read_link_gen_if
//
// Purpose: AXI-stream style receive bus feeding the FOFB link reader. There is
// no backpressure; a beat is transferred on every cycle where TVALID is high.
//
// Signals:
//   TVALID  stream beat valid
//   TLAST   last beat of a packet
//   TDATA   32-bit stream data
//
// Modports:
//   master  drives the stream (link PHY side / testbench)
//   slave   consumes the stream (fofb_read_link_gen)
// ---------------------------------------------------------------------------
interface fofb_read_link_gen_if;
    logic        TVALID;
    logic        TLAST;
    logic [31:0] TDATA;

    modport master (output TVALID, output TLAST, output TDATA);
    modport slave  (input  TVALID, input  TLAST, input  TDATA);
endinterface

// File: rtl/fofb_read_link_gen.sv
// ---------------------------------------------------------------------------
// fofb_read_link_gen
//
// Purpose: parses BPM records arriving on the Aurora receive stream, stores
// each record in a per-BPM DPRAM, tracks which BPMs arrived in the current
// fast-acquisition frame, counts good packets per frame, and publishes a
// per-packet status pulse plus four saturating event counters.
//
// Record layout: one header beat followed by PAYLOAD_WORDS payload beats.
//   header  : [31:16] magic, [15] FOFB enabled, [10 +: CELL_INDEX_WIDTH] cell,
//             [0 +: FOFB_INDEX_WIDTH] BPM index
//   final payload word: [31] BPM absent (no DPRAM write), [30] bad packet
// A packet is one or more records; TLAST marks the end of the packet.
//
// Ports:
//   auroraClk          clock
//   auroraReset        synchronous active-high reset
//   FAstrobe           frame start: clears bitmap / cell counter / packet map
//   allBPMpresent      inhibits DPRAM writes and bitmap merges
//   axis               receive stream (slave modport)
//   statusStrobe       one-cycle pulse, statusCode valid
//   statusCode         0 success, 1 bad header, 2 bad size, 3 bad packet
//   statusFOFBenabled  header bit 15 of the latest accepted header
//   statusCellIndex    cell index of the latest accepted header
//   bpmBitmap          BPMs received in this frame
//   cellCounter        good packets in this frame (wraps)
//   count*             saturating per-status event counters
//   counterClear       zeroes the four counters (wins over an increment)
//   readoutAddress     DPRAM read address
//   readoutData        registered DPRAM read data, word k at bits 32k +: 32
// ---------------------------------------------------------------------------
module fofb_read_link_gen #(
    parameter int          FOFB_INDEX_WIDTH = 9,
    parameter int          CELL_INDEX_WIDTH = 5,
    parameter int          PAYLOAD_WORDS    = 3,
    parameter logic [15:0] HEADER_MAGIC     = 16'hA5BE,
    parameter int          COUNTER_WIDTH    = 16
) (
    input  logic                             auroraClk,
    input  logic                             auroraReset,
    input  logic                             FAstrobe,
    input  logic                             allBPMpresent,
    fofb_read_link_gen_if.slave              axis,
    output logic                             statusStrobe,
    output logic [1:0]                       statusCode,
    output logic                             statusFOFBenabled,
    output logic [CELL_INDEX_WIDTH-1:0]      statusCellIndex,
    output logic [(1<<FOFB_INDEX_WIDTH)-1:0] bpmBitmap,
    output logic [CELL_INDEX_WIDTH:0]        cellCounter,
    output logic [COUNTER_WIDTH-1:0]         countSuccess,
    output logic [COUNTER_WIDTH-1:0]         countBadHeader,
    output logic [COUNTER_WIDTH-1:0]         countBadSize,
    output logic [COUNTER_WIDTH-1:0]         countBadPacket,
    input  logic                             counterClear,
    input  logic [FOFB_INDEX_WIDTH-1:0]      readoutAddress,
    output logic [32*PAYLOAD_WORDS-1:0]      readoutData
);

    localparam int NBPM = 1 << FOFB_INDEX_WIDTH;
    localparam int RW   = 32 * PAYLOAD_WORDS;
    localparam int WW   = $clog2(PAYLOAD_WORDS);
    localparam logic [WW-1:0] LAST_WORD = WW'(PAYLOAD_WORDS - 1);

    localparam logic [1:0] CODE_SUCCESS    = 2'd0;
    localparam logic [1:0] CODE_BAD_HEADER = 2'd1;
    localparam logic [1:0] CODE_BAD_SIZE   = 2'd2;
    localparam logic [1:0] CODE_BAD_PACKET = 2'd3;

    typedef enum logic [1:0] {
        ST_HEADER  = 2'd0,
        ST_PAYLOAD = 2'd1,
        ST_DISCARD = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    state_t                      state_q, state_d;
    logic [WW-1:0]               word_q, word_d;

    logic [FOFB_INDEX_WIDTH-1:0] fofb_index_q;
    logic [CELL_INDEX_WIDTH-1:0] cell_index_q;
    logic                        fofb_enabled_q;
    logic [31:0]                 payload_q [PAYLOAD_WORDS-1];

    logic                        status_strobe_q;
    logic [1:0]                  status_code_q;
    logic [NBPM-1:0]             pkt_map_q;
    logic                        map_stale_q;
    logic [NBPM-1:0]             bitmap_q;
    logic [CELL_INDEX_WIDTH:0]   cell_count_q;
    logic                        merge_q;
    logic                        wr_en_q;
    logic [FOFB_INDEX_WIDTH-1:0] wr_addr_q;
    logic [RW-1:0]               wr_data_q;
    logic [RW-1:0]               readout_q;
    logic [COUNTER_WIDTH-1:0]    count_q [4];

    logic [RW-1:0]               mem [NBPM];

    // ------------------------------------------------------------------
    // Per-beat decode results
    // ------------------------------------------------------------------
    logic        beat;
    logic        magic_ok;
    logic        hdr_beat_d;
    logic        hdr_ok_d;
    logic        store_word_d;
    logic        set_map_d;
    logic        write_req_d;
    logic        status_ev_d;
    logic [1:0]  status_code_d;
    logic        good_end_d;
    logic [RW-1:0]   record_d;
    logic [NBPM-1:0] index_onehot;

    // A concurrent FAstrobe swallows the beat entirely.
    assign beat         = axis.TVALID && !FAstrobe;
    assign magic_ok     = (axis.TDATA[31:16] == HEADER_MAGIC);
    assign index_onehot = NBPM'(1) << fofb_index_q;

    // Full record as written to the DPRAM: stored words plus the final word
    // straight off the bus.
    generate
        for (genvar gi = 0; gi < PAYLOAD_WORDS - 1; gi++) begin : g_record
            assign record_d[32*gi +: 32] = payload_q[gi];
        end
    endgenerate
    assign record_d[RW-32 +: 32] = axis.TDATA;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge auroraClk) begin
        if (auroraReset) begin
            state_q <= ST_HEADER;
            word_q  <= '0;
        end else if (FAstrobe) begin
            state_q <= ST_HEADER;
            word_q  <= '0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and beat classification
    // ------------------------------------------------------------------
    always_comb begin
        state_d       = state_q;
        word_d        = word_q;
        hdr_beat_d    = 1'b0;
        hdr_ok_d      = 1'b0;
        store_word_d  = 1'b0;
        set_map_d     = 1'b0;
        write_req_d   = 1'b0;
        status_ev_d   = 1'b0;
        status_code_d = CODE_SUCCESS;
        good_end_d    = 1'b0;

        if (beat) begin
            case (state_q)
                ST_HEADER: begin
                    hdr_beat_d = 1'b1;
                    if (axis.TLAST) begin
                        // Packet ended on a header beat: too short.
                        status_ev_d   = 1'b1;
                        status_code_d = CODE_BAD_SIZE;
                    end else if (magic_ok) begin
                        hdr_ok_d = 1'b1;
                        word_d   = '0;
                        state_d  = ST_PAYLOAD;
                    end else begin
                        status_ev_d   = 1'b1;
                        status_code_d = CODE_BAD_HEADER;
                        state_d       = ST_DISCARD;
                    end
                end

                ST_PAYLOAD: begin
                    if (word_q == LAST_WORD) begin
                        set_map_d   = !axis.TDATA[31];
                        write_req_d = !axis.TDATA[31] && !allBPMpresent;
                        state_d     = ST_HEADER;
                        if (axis.TLAST) begin
                            status_ev_d = 1'b1;
                            if (axis.TDATA[30]) begin
                                status_code_d = CODE_BAD_PACKET;
                            end else begin
                                status_code_d = CODE_SUCCESS;
                                good_end_d    = 1'b1;
                            end
                        end
                    end else if (axis.TLAST) begin
                        status_ev_d   = 1'b1;
                        status_code_d = CODE_BAD_SIZE;
                        state_d       = ST_HEADER;
                    end else begin
                        store_word_d = 1'b1;
                        word_d       = word_q + 1'b1;
                    end
                end

                ST_DISCARD: begin
                    if (axis.TLAST) begin
                        state_d = ST_HEADER;
                    end
                end

                default: state_d = ST_HEADER;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        statusStrobe      = status_strobe_q;
        statusCode        = status_code_q;
        statusFOFBenabled = fofb_enabled_q;
        statusCellIndex   = cell_index_q;
        bpmBitmap         = bitmap_q;
        cellCounter       = cell_count_q;
        countSuccess      = count_q[0];
        countBadHeader    = count_q[1];
        countBadSize      = count_q[2];
        countBadPacket    = count_q[3];
        readoutData       = readout_q;
    end

    // ------------------------------------------------------------------
    // Header fields of the record being parsed
    // ------------------------------------------------------------------
    always_ff @(posedge auroraClk) begin
        if (auroraReset) begin
            fofb_index_q   <= '0;
            cell_index_q   <= '0;
            fofb_enabled_q <= 1'b0;
        end else if (hdr_ok_d) begin
            fofb_index_q   <= axis.TDATA[FOFB_INDEX_WIDTH-1:0];
            cell_index_q   <= axis.TDATA[10 +: CELL_INDEX_WIDTH];
            fofb_enabled_q <= axis.TDATA[15];
        end
    end

    // Payload words other than the final one are held until the record ends.
    generate
        for (genvar gi = 0; gi < PAYLOAD_WORDS - 1; gi++) begin : g_payload
            always_ff @(posedge auroraClk) begin
                if (auroraReset) begin
                    payload_q[gi] <= '0;
                end else if (store_word_d && (word_q == WW'(gi))) begin
                    payload_q[gi] <= axis.TDATA;
                end
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // Status, frame bookkeeping and pending DPRAM write
    // ------------------------------------------------------------------
    always_ff @(posedge auroraClk) begin
        if (auroraReset) begin
            status_strobe_q <= 1'b0;
            status_code_q   <= '0;
            pkt_map_q       <= '0;
            map_stale_q     <= 1'b0;
            bitmap_q        <= '0;
            cell_count_q    <= '0;
            merge_q         <= 1'b0;
            wr_en_q         <= 1'b0;
            wr_addr_q       <= '0;
            wr_data_q       <= '0;
        end else begin
            status_strobe_q <= status_ev_d;
            if (status_ev_d) begin
                status_code_q <= status_code_d;
            end

            wr_en_q <= write_req_d;
            if (write_req_d) begin
                wr_addr_q <= fofb_index_q;
                wr_data_q <= record_d;
            end

            if (good_end_d) begin
                cell_count_q <= cell_count_q + 1'b1;
            end

            // The packet map is merged one cycle after a successful packet
            // end; it is only cleared at the next header, so the merge always
            // sees the complete packet.
            merge_q <= good_end_d && !allBPMpresent;
            if (merge_q) begin
                bitmap_q <= bitmap_q | pkt_map_q;
            end

            if (hdr_beat_d && map_stale_q) begin
                pkt_map_q <= '0;
            end else if (set_map_d) begin
                pkt_map_q <= pkt_map_q | index_onehot;
            end

            if (status_ev_d) begin
                map_stale_q <= 1'b1;
            end else if (hdr_beat_d) begin
                map_stale_q <= 1'b0;
            end

            // Frame start wins over everything above, including a pending
            // merge or write from the previous cycle.
            if (FAstrobe) begin
                pkt_map_q    <= '0;
                map_stale_q  <= 1'b0;
                bitmap_q     <= '0;
                cell_count_q <= '0;
                merge_q      <= 1'b0;
                wr_en_q      <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Saturating event counters, one per status code
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_counter
            always_ff @(posedge auroraClk) begin
                if (auroraReset || counterClear) begin
                    count_q[gi] <= '0;
                end else if (status_strobe_q && (status_code_q == 2'(gi)) &&
                             (count_q[gi] != {COUNTER_WIDTH{1'b1}})) begin
                    count_q[gi] <= count_q[gi] + 1'b1;
                end
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // Per-BPM record DPRAM. The write lands the cycle after the final
    // payload beat; FAstrobe in that cycle cancels it. Read is registered
    // and returns the old contents on a same-address collision.
    // ------------------------------------------------------------------
    always_ff @(posedge auroraClk) begin
        if (wr_en_q && !FAstrobe && !auroraReset) begin
            mem[wr_addr_q] <= wr_data_q;
        end
    end

    always_ff @(posedge auroraClk) begin
        if (auroraReset) begin
            readout_q <= '0;
        end else begin
            readout_q <= mem[readoutAddress];
        end
    end

endmodule

// File: tb/tb_fofb_read_link_gen.sv
// ---------------------------------------------------------------------------
// tb_fofb_read_link_gen
//
// Directed bench for fofb_read_link_gen. Expected status codes are queued as
// each terminating beat is driven; a monitor pops and compares them whenever
// statusStrobe is seen. The DUT is built with 4-bit counters so saturation is
// reachable with a short burst of bad-size packets.
// ---------------------------------------------------------------------------
module tb_fofb_read_link_gen;

    localparam int FIW  = 9;
    localparam int CW   = 5;
    localparam int PW   = 3;
    localparam int CNTW = 4;
    localparam int NB   = 1 << FIW;
    localparam int RW   = 32 * PW;

    logic            clk = 1'b0;
    logic            rst;
    logic            fa;
    logic            abp;
    logic            clr;
    logic [FIW-1:0]  raddr;

    logic            statusStrobe;
    logic [1:0]      statusCode;
    logic            statusFOFBenabled;
    logic [CW-1:0]   statusCellIndex;
    logic [NB-1:0]   bpmBitmap;
    logic [CW:0]     cellCounter;
    logic [CNTW-1:0] countSuccess;
    logic [CNTW-1:0] countBadHeader;
    logic [CNTW-1:0] countBadSize;
    logic [CNTW-1:0] countBadPacket;
    logic [RW-1:0]   readoutData;

    fofb_read_link_gen_if axis ();

    fofb_read_link_gen #(
        .FOFB_INDEX_WIDTH (FIW),
        .CELL_INDEX_WIDTH (CW),
        .PAYLOAD_WORDS    (PW),
        .HEADER_MAGIC     (16'hA5BE),
        .COUNTER_WIDTH    (CNTW)
    ) dut (
        .auroraClk         (clk),
        .auroraReset       (rst),
        .FAstrobe          (fa),
        .allBPMpresent     (abp),
        .axis              (axis),
        .statusStrobe      (statusStrobe),
        .statusCode        (statusCode),
        .statusFOFBenabled (statusFOFBenabled),
        .statusCellIndex   (statusCellIndex),
        .bpmBitmap         (bpmBitmap),
        .cellCounter       (cellCounter),
        .countSuccess      (countSuccess),
        .countBadHeader    (countBadHeader),
        .countBadSize      (countBadSize),
        .countBadPacket    (countBadPacket),
        .counterClear      (clr),
        .readoutAddress    (raddr),
        .readoutData       (readoutData)
    );

    always #5 clk = ~clk;

    int         errors = 0;
    int         checks = 0;
    logic [1:0] sb_q [$];

    task automatic chk(input string tag, input logic [NB-1:0] obs, input logic [NB-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Status monitor: every strobe must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rst === 1'b0 && statusStrobe === 1'b1) begin
            checks++;
            assert (sb_q.size() != 0) else begin
                errors++;
                $error("FAIL unexpected_status: observed code=%0d expected=no strobe", statusCode);
            end
            if (sb_q.size() != 0) begin
                logic [1:0] e;
                e = sb_q.pop_front();
                chk("status_code", NB'(statusCode), NB'(e));
            end
        end
    end

    task automatic send(input logic [31:0] d, input logic last);
        @(negedge clk);
        axis.TVALID = 1'b1;
        axis.TLAST  = last;
        axis.TDATA  = d;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            axis.TVALID = 1'b0;
            axis.TLAST  = 1'b0;
        end
    endtask

    task automatic rec(input logic [31:0] h, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] c);
        send(h, 1'b0);
        send(a, 1'b0);
        send(b, 1'b0);
        send(c, 1'b1);
    endtask

    task automatic rd(input logic [FIW-1:0] addr, output logic [RW-1:0] data);
        @(negedge clk);
        raddr = addr;
        @(negedge clk);
        data = readoutData;
    endtask

    logic [RW-1:0] rdata;
    logic [NB-1:0] ebm;

    initial begin
        rst         = 1'b1;
        fa          = 1'b0;
        abp         = 1'b0;
        clr         = 1'b0;
        raddr       = '0;
        axis.TVALID = 1'b0;
        axis.TLAST  = 1'b0;
        axis.TDATA  = '0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_strobe",  NB'(statusStrobe), '0);
        chk("rst_code",    NB'(statusCode), '0);
        chk("rst_bitmap",  bpmBitmap, '0);
        chk("rst_cellcnt", NB'(cellCounter), '0);
        chk("rst_cntsucc", NB'(countSuccess), '0);
        chk("rst_readout", NB'(readoutData), '0);
        rst = 1'b0;
        idle(2);

        // Good packet: enable 1, cell 1, index 5
        sb_q.push_back(2'd0);
        rec(32'hA5BE_8405, 32'h1, 32'h2, 32'h3);
        idle(3);
        ebm = '0; ebm[5] = 1'b1;
        chk("good_cellcnt", NB'(cellCounter), NB'(1));
        chk("good_bitmap",  bpmBitmap, ebm);
        chk("good_enable",  NB'(statusFOFBenabled), NB'(1));
        chk("good_cell",    NB'(statusCellIndex), NB'(1));
        chk("good_cntsucc", NB'(countSuccess), NB'(1));
        rd(9'd5, rdata);
        chk("good_read5", NB'(rdata), NB'({32'h3, 32'h2, 32'h1}));

        // Bad magic, rest of packet discarded
        sb_q.push_back(2'd1);
        send(32'h1234_0005, 1'b0);
        send(32'hA, 1'b0);
        send(32'hB, 1'b0);
        send(32'hC, 1'b1);
        idle(3);
        chk("badhdr_cnt",     NB'(countBadHeader), NB'(1));
        chk("badhdr_cellcnt", NB'(cellCounter), NB'(1));
        rd(9'd5, rdata);
        chk("badhdr_read5", NB'(rdata), NB'({32'h3, 32'h2, 32'h1}));

        // TLAST on second payload beat, then a normal packet (cell 3, index 8)
        sb_q.push_back(2'd2);
        send(32'hA5BE_0407, 1'b0);
        send(32'h11, 1'b0);
        send(32'h22, 1'b1);
        sb_q.push_back(2'd0);
        rec(32'hA5BE_0C08, 32'h31, 32'h32, 32'h33);
        idle(3);
        ebm[8] = 1'b1;
        chk("size_cnt",     NB'(countBadSize), NB'(1));
        chk("size_cntsucc", NB'(countSuccess), NB'(2));
        chk("size_cellcnt", NB'(cellCounter), NB'(2));
        chk("size_bitmap",  bpmBitmap, ebm);
        chk("size_cell",    NB'(statusCellIndex), NB'(3));
        chk("size_enable",  NB'(statusFOFBenabled), NB'(0));
        rd(9'd8, rdata);
        chk("size_read8", NB'(rdata), NB'({32'h33, 32'h32, 32'h31}));

        // Bad packet flag: DPRAM written, bitmap and cell count untouched
        sb_q.push_back(2'd3);
        rec(32'hA5BE_0409, 32'h41, 32'h42, 32'h4000_0000);
        idle(3);
        chk("badpkt_cnt",     NB'(countBadPacket), NB'(1));
        chk("badpkt_cellcnt", NB'(cellCounter), NB'(2));
        chk("badpkt_bitmap",  bpmBitmap, ebm);
        rd(9'd9, rdata);
        chk("badpkt_read9", NB'(rdata), NB'({32'h4000_0000, 32'h42, 32'h41}));

        // BPM-absent flag on index 5: no write, still a success
        sb_q.push_back(2'd0);
        rec(32'hA5BE_0405, 32'h51, 32'h52, 32'h8000_0000);
        idle(3);
        chk("absent_cellcnt", NB'(cellCounter), NB'(3));
        chk("absent_bitmap",  bpmBitmap, ebm);
        rd(9'd5, rdata);
        chk("absent_read5", NB'(rdata), NB'({32'h3, 32'h2, 32'h1}));

        // Frame start clears bitmap and cell count
        @(negedge clk);
        fa = 1'b1;
        @(negedge clk);
        fa = 1'b0;
        chk("fa_bitmap",  bpmBitmap, '0);
        chk("fa_cellcnt", NB'(cellCounter), '0);

        // allBPMpresent: no write, no bitmap merge, cell count still counts
        abp = 1'b1;
        sb_q.push_back(2'd0);
        rec(32'hA5BE_0408, 32'h61, 32'h62, 32'h63);
        idle(3);
        abp = 1'b0;
        chk("abp_bitmap",  bpmBitmap, '0);
        chk("abp_cellcnt", NB'(cellCounter), NB'(1));
        chk("abp_cntsucc", NB'(countSuccess), NB'(4));
        rd(9'd8, rdata);
        chk("abp_read8", NB'(rdata), NB'({32'h33, 32'h32, 32'h31}));

        // Frame start mid-record (with a concurrent TLAST beat), then index 13
        send(32'hA5BE_040C, 1'b0);
        send(32'h71, 1'b0);
        @(negedge clk);
        fa          = 1'b1;
        axis.TVALID = 1'b1;
        axis.TLAST  = 1'b1;
        axis.TDATA  = 32'h72;
        @(negedge clk);
        fa          = 1'b0;
        axis.TVALID = 1'b0;
        axis.TLAST  = 1'b0;
        sb_q.push_back(2'd0);
        rec(32'hA5BE_340D, 32'h81, 32'h82, 32'h83);
        idle(3);
        ebm = '0; ebm[13] = 1'b1;
        chk("abort_bitmap",  bpmBitmap, ebm);
        chk("abort_cellcnt", NB'(cellCounter), NB'(1));
        chk("abort_cell",    NB'(statusCellIndex), NB'(13));
        chk("abort_cntsucc", NB'(countSuccess), NB'(5));

        // Saturation: 20 back-to-back single-beat bad-size packets
        for (int i = 0; i < 20; i++) begin
            sb_q.push_back(2'd2);
            send(32'hA5BE_0401, 1'b1);
        end
        idle(3);
        chk("sat_badsize", NB'(countBadSize), NB'({CNTW{1'b1}}));
        sb_q.push_back(2'd2);
        send(32'hA5BE_0401, 1'b1);
        idle(3);
        chk("sat_hold", NB'(countBadSize), NB'({CNTW{1'b1}}));

        // Counter clear
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        chk("clr_succ",    NB'(countSuccess), '0);
        chk("clr_badhdr",  NB'(countBadHeader), '0);
        chk("clr_badsize", NB'(countBadSize), '0);
        chk("clr_badpkt",  NB'(countBadPacket), '0);

        // Clear coincident with the increment cycle wins
        sb_q.push_back(2'd2);
        send(32'hA5BE_0401, 1'b1);
        @(negedge clk);
        axis.TVALID = 1'b0;
        axis.TLAST  = 1'b0;
        clr         = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        idle(2);
        chk("clr_wins", NB'(countBadSize), '0);

        idle(3);
        chk("sb_empty", NB'(sb_q.size()), '0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
